// File: rtl/rv32i_types_pkg.sv
// Shared RV32I datapath types for the writeback path: words, register indices,
// buffered result entries and the writeback arbitration state.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef struct packed {
    word_t    wdata;
    regbits_t rd;
    logic     wen;
  } wb_entry_t;

  typedef enum logic {
    LSU_PRIO = 1'b0,
    AU_FORCE = 1'b1
  } wb_arb_state_t;

  // x0 is hardwired to zero, so a write to it retires without touching the file.
  function automatic logic writes_reg(input wb_entry_t e);
    return e.wen && (e.rd != '0);
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small result FIFO for buffered arithmetic-unit writebacks. Full/empty come from
// the occupancy count; the head is visible only after the write edge (no bypass).
module wb_result_fifo
  import rv32i_types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  wb_entry_t              push_data,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  // Full blocks a push even when the head leaves on the same edge.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: LSU results normally win the register-file port, buffered AU
// results are forced through after STARVE_LIMIT consecutive losses.
module wb_arbiter
  import rv32i_types_pkg::*;
#(
  parameter int AU_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      flush,
  input  logic                      au_valid,
  output logic                      au_ready,
  input  word_t                     au_wdata,
  input  regbits_t                  au_rd,
  input  logic                      au_wen,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  word_t                     lsu_wdata,
  input  regbits_t                  lsu_rd,
  input  logic                      lsu_wen,
  output logic                      wb_wen,
  output regbits_t                  wb_rd,
  output word_t                     wb_wdata,
  output logic                      wb_retire,
  output logic [$clog2(AU_DEPTH):0] au_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  wb_arb_state_t state_reg;
  wb_arb_state_t state_next;
  logic [SW-1:0] starve_reg;
  logic [SW-1:0] starve_next;
  logic          sel_au;
  logic          sel_lsu;
  logic          fifo_full;
  logic          fifo_empty;
  wb_entry_t     fifo_head;
  wb_entry_t     sel_entry;
  logic          wb_wen_reg;
  logic          wb_retire_reg;
  regbits_t      wb_rd_reg;
  word_t         wb_wdata_reg;

  wb_result_fifo #(
    .DEPTH(AU_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .flush     (flush),
    .push      (au_valid),
    .push_data ('{wdata: au_wdata, rd: au_rd, wen: au_wen}),
    .pop       (sel_au),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (au_count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= LSU_PRIO;
      starve_reg <= '0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;
    sel_au      = 1'b0;
    sel_lsu     = 1'b0;
    if (flush) begin
      state_next  = LSU_PRIO;
      starve_next = '0;
    end else begin
      case (state_reg)
        LSU_PRIO: begin
          if (lsu_valid) begin
            sel_lsu = 1'b1;
            if (!fifo_empty) begin
              starve_next = starve_reg + 1'b1;
              if (starve_reg + 1'b1 == STARVE_MAX) begin
                state_next = AU_FORCE;
              end
            end
          end else if (!fifo_empty) begin
            sel_au      = 1'b1;
            starve_next = '0;
          end
        end
        AU_FORCE: begin
          // Only reachable with a waiting head, so the FIFO cannot be empty here.
          sel_au      = 1'b1;
          starve_next = '0;
          state_next  = LSU_PRIO;
        end
        default: begin
          state_next  = LSU_PRIO;
          starve_next = '0;
        end
      endcase
    end
  end

  assign lsu_ready = sel_lsu;
  assign au_ready  = !fifo_full;
  assign sel_entry = sel_au ? fifo_head : '{wdata: lsu_wdata, rd: lsu_rd, wen: lsu_wen};

  // rd/wdata hold across idle cycles; only the strobes drop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb_wen_reg    <= 1'b0;
      wb_retire_reg <= 1'b0;
      wb_rd_reg     <= '0;
      wb_wdata_reg  <= '0;
    end else if (sel_au || sel_lsu) begin
      wb_wen_reg    <= writes_reg(sel_entry);
      wb_retire_reg <= 1'b1;
      wb_rd_reg     <= sel_entry.rd;
      wb_wdata_reg  <= sel_entry.wdata;
    end else begin
      wb_wen_reg    <= 1'b0;
      wb_retire_reg <= 1'b0;
    end
  end

  assign wb_wen    = wb_wen_reg;
  assign wb_retire = wb_retire_reg;
  assign wb_rd     = wb_rd_reg;
  assign wb_wdata  = wb_wdata_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations and a randomized phase.
module tb_wb_arbiter;

  localparam int AU_DEPTH     = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        au_valid;
  logic        au_ready;
  logic [31:0] au_wdata;
  logic [4:0]  au_rd;
  logic        au_wen;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [31:0] lsu_wdata;
  logic [4:0]  lsu_rd;
  logic        lsu_wen;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        wb_retire;
  logic [1:0]  au_count;

  int checks   = 0;
  int failures = 0;

  wb_arbiter #(
    .AU_DEPTH    (AU_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .flush    (flush),
    .au_valid (au_valid),
    .au_ready (au_ready),
    .au_wdata (au_wdata),
    .au_rd    (au_rd),
    .au_wen   (au_wen),
    .lsu_valid(lsu_valid),
    .lsu_ready(lsu_ready),
    .lsu_wdata(lsu_wdata),
    .lsu_rd   (lsu_rd),
    .lsu_wen  (lsu_wen),
    .wb_wen   (wb_wen),
    .wb_rd    (wb_rd),
    .wb_wdata (wb_wdata),
    .wb_retire(wb_retire),
    .au_count (au_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending AU results and a count of losses of the
  // current head; a head that has lost STARVE_LIMIT times in a row must go next.
  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        wen;
  } ent_t;

  ent_t        q[$];
  int          losses;
  logic        m_wen;
  logic        m_retire;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;
  int          ms;
  bit          m_push;
  ent_t        e;
  int          cs;

  // 0: nothing, 1: LSU, 2: AU head
  function automatic int model_sel();
    if (flush) return 0;
    if (losses == STARVE_LIMIT) return 2;
    if (lsu_valid) return 1;
    if (q.size() > 0) return 2;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      losses   = 0;
      m_wen    = 1'b0;
      m_retire = 1'b0;
      m_rd     = '0;
      m_wdata  = '0;
    end else begin
      ms     = model_sel();
      m_push = au_valid && !flush && (q.size() != AU_DEPTH);
      if (flush) begin
        q.delete();
        losses   = 0;
        m_wen    = 1'b0;
        m_retire = 1'b0;
      end else begin
        if (ms == 1) begin
          if (q.size() > 0) losses++;
          m_retire = 1'b1;
          m_wen    = lsu_wen && (lsu_rd != 0);
          m_rd     = lsu_rd;
          m_wdata  = lsu_wdata;
        end else if (ms == 2) begin
          e        = q.pop_front();
          losses   = 0;
          m_retire = 1'b1;
          m_wen    = e.wen && (e.rd != 0);
          m_rd     = e.rd;
          m_wdata  = e.d;
        end else begin
          m_retire = 1'b0;
          m_wen    = 1'b0;
        end
        if (m_push) q.push_back('{d: au_wdata, rd: au_rd, wen: au_wen});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      cs = model_sel();
      check("lsu_ready", lsu_ready, (cs == 1));
      check("au_ready", au_ready, (q.size() != AU_DEPTH));
      check("au_count", au_count, q.size());
      check("wb_wen", wb_wen, m_wen);
      check("wb_retire", wb_retire, m_retire);
      check("wb_rd", wb_rd, m_rd);
      check("wb_wdata", wb_wdata, m_wdata);
    end
  end

  task automatic set_in(input logic av, input logic [31:0] ad, input logic [4:0] ard,
                        input logic aw, input logic lv, input logic [31:0] ld,
                        input logic [4:0] lrd, input logic lw, input logic fl);
    au_valid  = av;
    au_wdata  = ad;
    au_rd     = ard;
    au_wen    = aw;
    lsu_valid = lv;
    lsu_wdata = ld;
    lsu_rd    = lrd;
    lsu_wen   = lw;
    flush     = fl;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  logic starve_exp [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_wen", wb_wen, 0);
    check("rst_wb_retire", wb_retire, 0);
    check("rst_au_count", au_count, 0);
    check("rst_au_ready", au_ready, 1);
    rst = 1'b0;
    next();

    // AU only: accepted cycle 0, on wb in cycle 2 only
    set_in(1, 32'h0000_00A5, 3, 1, 0, 0, 0, 0, 0);
    next();
    idle();
    #3 check("au_only_c1_retire", wb_retire, 0);
    next();
    #3;
    check("au_only_wen", wb_wen, 1);
    check("au_only_rd", wb_rd, 3);
    check("au_only_wdata", wb_wdata, 32'hA5);
    check("au_only_retire", wb_retire, 1);
    next();
    #3 check("au_only_c3_retire", wb_retire, 0);
    next();

    // Fill with LSU held busy
    set_in(1, 32'h10, 4, 1, 1, 32'h1111, 1, 1, 0);
    next();
    set_in(1, 32'h20, 5, 1, 1, 32'h1111, 1, 1, 0);
    next();
    set_in(1, 32'h30, 6, 1, 1, 32'h1111, 1, 1, 0);
    #3;
    check("fill_count", au_count, 2);
    check("fill_ready", au_ready, 0);
    next();
    #3 check("fill_stall", au_ready, 0);
    next();
    next();
    #3;
    check("fill_force_lsu_ready", lsu_ready, 0);
    check("fill_force_au_ready", au_ready, 0);
    next();
    #3;
    check("fill_resume_ready", au_ready, 1);
    check("fill_resume_count", au_count, 1);
    next();
    idle();
    #3 check("fill_third_in", au_count, 2);
    repeat (4) next();

    // Starvation: one buffered entry against continuous LSU traffic
    set_in(1, 32'hBEEF, 9, 1, 0, 0, 0, 0, 0);
    next();
    set_in(0, 0, 0, 0, 1, 32'h4444, 8, 1, 0);
    for (int i = 0; i < 6; i++) begin
      #3 check("starve_lsu_ready", lsu_ready, starve_exp[i]);
      if (i == 5) begin
        check("starve_au_rd", wb_rd, 9);
        check("starve_au_wdata", wb_wdata, 32'hBEEF);
      end
      next();
    end
    idle();
    repeat (2) next();

    // x0 write and no-write load both retire without a register write
    set_in(1, 32'h77, 0, 1, 0, 0, 0, 0, 0);
    next();
    idle();
    next();
    set_in(0, 0, 0, 0, 1, 32'h88, 7, 0, 0);
    #3;
    check("x0_retire", wb_retire, 1);
    check("x0_wen", wb_wen, 0);
    check("x0_rd", wb_rd, 0);
    next();
    idle();
    #3;
    check("nowen_retire", wb_retire, 1);
    check("nowen_wen", wb_wen, 0);
    check("nowen_rd", wb_rd, 7);
    next();
    repeat (2) next();

    // Flush with two entries buffered and a new AU result offered
    set_in(1, 32'h51, 10, 1, 1, 32'h2222, 2, 1, 0);
    next();
    set_in(1, 32'h52, 11, 1, 1, 32'h2222, 2, 1, 0);
    next();
    set_in(1, 32'h53, 13, 1, 1, 32'h2222, 2, 1, 1);
    #3;
    check("flush_lsu_ready", lsu_ready, 0);
    check("flush_au_ready", au_ready, 0);
    check("flush_pre_count", au_count, 2);
    next();
    idle();
    #3;
    check("flush_count", au_count, 0);
    check("flush_retire", wb_retire, 0);
    next();
    #3;
    check("flush_dropped_retire", wb_retire, 0);
    check("flush_dropped_count", au_count, 0);
    next();

    // Asynchronous reset mid-operation
    set_in(1, 32'h61, 14, 1, 1, 32'hCAFE, 12, 1, 0);
    next();
    next();
    #2;
    check("mid_pre_wen", wb_wen, 1);
    check("mid_pre_count", au_count, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_wen", wb_wen, 0);
    check("mid_rst_retire", wb_retire, 0);
    check("mid_rst_count", au_count, 0);
    check("mid_rst_ready", au_ready, 1);
    idle();
    next();
    rst = 1'b0;
    next();

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      set_in($urandom_range(0, 1) == 1, $urandom, 5'($urandom_range(0, 31)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 99) < 70, $urandom,
             5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
             $urandom_range(0, 99) < 4);
      next();
    end
    idle();
    repeat (6) next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly downstream of the arithmetic unit (and the load-store unit).
- Buffers arithmetic-unit results (wdata_au, rd, wen) in a small FIFO.
- Arbitrates each cycle between the buffered AU head and the load-store unit (LSU) for the single register-file write port, then drives a registered writeback.
- LSU has normal priority. A starvation counter forces AU service after a bounded wait.

Parameters:
- AU_DEPTH, 2, AU result FIFO entries; power of 2, ≥2.
- STARVE_LIMIT, 4, consecutive cycles an AU head may lose arbitration before it is forced through; ≥1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; asynchronous, active-high.
- flush  input  1  synchronous pipeline flush.
- au_valid  input  1  AU result valid.
- au_ready  output  1  FIFO can accept; equals !full.
- au_wdata  input  32  AU result data (word_t).
- au_rd  input  5  destination register.
- au_wen  input  1  result writes a register.
- lsu_valid  input  1  LSU result valid.
- lsu_ready  output  1  LSU result accepted this cycle.
- lsu_wdata  input  32  load data.
- lsu_rd  input  5  destination register.
- lsu_wen  input  1  result writes a register.
- wb_wen  output  1  register-file write enable.
- wb_rd  output  5  register-file write address.
- wb_wdata  output  32  register-file write data.
- wb_retire  output  1  one result retired (instret pulse).
- au_count  output  $clog2(AU_DEPTH)+1  FIFO occupancy.

Behaviour:
- Interface: one clock, CLK; RST is asynchronous and active-high.
- Reset:
  - Applied: FIFO empty, pointers 0, starve_cnt 0, arbitration state LSU_PRIO.
  - All wb_* outputs and au_count are 0; au_ready=1.
  - Reset mid-operation discards all buffered results.
- Enqueue: on au_valid && au_ready && !flush, write {au_wdata, au_rd, au_wen} at the write pointer. Pointers wrap modulo AU_DEPTH. The full/empty distinction comes from occupancy, not pointer equality.
- Full: au_ready = (au_count != AU_DEPTH), purely combinational from the count.
  - No enqueue while full, even if a dequeue happens in the same cycle.
  - Simultaneous enqueue and dequeue when not full leaves au_count unchanged.
- No bypass: an entry becomes arbitration-eligible the cycle after it is written.
- AU latency: accepted in cycle N → earliest on wb_* in cycle N+2.
- Arbitration FSM, two states:
  - LSU_PRIO:
    - lsu_valid → LSU selected, lsu_ready=1.
    - Else if FIFO non-empty → AU head selected.
    - If the head is non-empty and LSU wins, starve_cnt increments.
    - When starve_cnt reaches STARVE_LIMIT, next state is AU_FORCE.
  - AU_FORCE:
    - lsu_ready=0; AU head selected (FIFO is guaranteed non-empty).
    - starve_cnt clears; next state LSU_PRIO.
  - starve_cnt clears whenever the AU head is dequeued.
- LSU latency: lsu_ready is combinational. A selected LSU result appears on wb_* in cycle N+1.
- Output register: selected entry latched at the clock edge.
  - wb_retire=1 for any selected entry.
  - wb_wen=1 only if entry wen=1 and rd≠0.
  - wb_rd and wb_wdata are loaded with the entry values.
  - With no selection: wb_retire=0, wb_wen=0, wb_rd and wb_wdata hold their previous values.
- Flush:
  - Same-edge effects: FIFO emptied, starve_cnt 0, state LSU_PRIO, wb_wen=0, wb_retire=0.
  - During the flush cycle, lsu_ready=0, no enqueue, no selection, and au_ready follows the pre-flush count.
- Width: all data is word_t (32 bits); no arithmetic on data. Counters saturate-free by construction.

Decomposition:
- rv32i_types_pkg: word_t, regbits_t (5-bit rd), wb_entry_t struct {word_t wdata; regbits_t rd; logic wen;}, wb_arb_state_t enum {LSU_PRIO, AU_FORCE}.
- One sub-module, wb_result_fifo: parameterised on depth; carries wb_entry_t, full/empty/count, and flush.

Test Plan:
- AU only: RST release, one AU result (wdata=0x0000_00A5, rd=3, wen=1) in cycle 0 → wb_wen=1, wb_rd=3, wb_wdata=0xA5 in cycle 2 only; wb_retire pulses once.
- Fill: 3 AU pushes with lsu_valid held 1 → au_ready=0 after 2 accepts, au_count=2, third push stalls until a dequeue.
- Starvation: FIFO holds 1 entry, lsu_valid=1 continuously → 4 LSU writebacks, then lsu_ready=0 for 1 cycle and the AU entry retires, then LSU resumes.
- x0 / no-write: AU entry rd=0 wen=1, then LSU entry rd=7 wen=0 → both give wb_retire=1 with wb_wen=0.
- Flush: 2 AU entries buffered, flush=1 with au_valid=1 → next cycle au_count=0, no retire, the au_valid result is dropped.
- Reset mid-operation: RST asserted asynchronously with 2 entries buffered and wb_wen=1 → wb_wen, wb_retire, au_count go to 0 immediately; au_ready=1.
